// File: rtl/mult_add_job_scheduler_if.sv
// Requester-side job/response signals and AXI4-Lite master channels of the
// multiply-add job scheduler, bundled for connection to the scheduler core.
interface mult_add_job_scheduler_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [63:0] req_c;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_err;

  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  modport master (
    input  req_valid, req_a, req_b, req_c, rsp_ready,
    input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
    input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
    output m_axi_awaddr, m_axi_awprot, m_axi_awvalid, m_axi_wdata, m_axi_wstrb,
    output m_axi_wvalid, m_axi_bready, m_axi_araddr, m_axi_arprot,
    output m_axi_arvalid, m_axi_rready
  );

  modport slave (
    output req_valid, req_a, req_b, req_c, rsp_ready,
    output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
    output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
    input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid, m_axi_wdata, m_axi_wstrb,
    input  m_axi_wvalid, m_axi_bready, m_axi_araddr, m_axi_arprot,
    input  m_axi_arvalid, m_axi_rready
  );
endinterface

// File: rtl/mult_add_job_scheduler.sv
// Shares one MyCpuMult multiply-add peripheral between two requesters:
// round-robin job pick, AXI4-Lite writes of A/B/C, result read-back.
module mult_add_job_scheduler #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  mult_add_job_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WB,
    S_RA,
    S_RD,
    S_RSP
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          k_q, k_d;
  logic                ptr_q, ptr_d;
  logic                id_q, id_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic [DATA_W-1:0]   op_c_q, op_c_d;
  logic                aw_pend_q, aw_pend_d;
  logic                w_pend_q, w_pend_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;

  logic                any_req;
  logic                win;
  logic [1:0]          grant;
  logic [DATA_W-1:0]   wdata_sel;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    any_req = |bus.req_valid;
    if (bus.req_valid == 2'b11) begin
      win = ~ptr_q;
    end else begin
      win = bus.req_valid[1];
    end
    grant = '0;
    if (state_q == S_IDLE && any_req && !ARESET) begin
      grant = win ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    unique case (k_q)
      2'd0:    wdata_sel = op_a_q;
      2'd1:    wdata_sel = op_b_q;
      default: wdata_sel = op_c_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_c_d     = op_c_q;
    aw_pend_d  = aw_pend_q;
    w_pend_d   = w_pend_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          ptr_d     = win;
          id_d      = win;
          op_a_d    = win ? bus.req_a[63:32] : bus.req_a[31:0];
          op_b_d    = win ? bus.req_b[63:32] : bus.req_b[31:0];
          op_c_d    = win ? bus.req_c[63:32] : bus.req_c[31:0];
          k_d       = 2'd0;
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
          state_d   = S_WR;
        end
      end
      S_WR: begin
        // AW and W retire independently; move on only once both have.
        aw_pend_d = aw_pend_q & ~bus.m_axi_awready;
        w_pend_d  = w_pend_q & ~bus.m_axi_wready;
        if (!aw_pend_d && !w_pend_d) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        if (bus.m_axi_bvalid) begin
          if (bus.m_axi_bresp != 2'b00) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            state_d    = S_RSP;
          end else if (k_q == 2'd2) begin
            state_d = S_RA;
          end else begin
            k_d       = k_q + 2'd1;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            state_d   = S_WR;
          end
        end
      end
      S_RA: begin
        if (bus.m_axi_arready) begin
          state_d = S_RD;
        end
      end
      S_RD: begin
        if (bus.m_axi_rvalid) begin
          rsp_data_d = bus.m_axi_rdata;
          rsp_err_d  = (bus.m_axi_rresp != 2'b00);
          state_d    = S_RSP;
        end
      end
      S_RSP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      ptr_q      <= 1'b1;
      id_q       <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_c_q     <= '0;
      aw_pend_q  <= 1'b0;
      w_pend_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_c_q     <= op_c_d;
      aw_pend_q  <= aw_pend_d;
      w_pend_q   <= w_pend_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    bus.req_ready     = grant;
    bus.rsp_valid     = (state_q == S_RSP);
    bus.rsp_id        = id_q;
    bus.rsp_data      = rsp_data_q;
    bus.rsp_err       = rsp_err_q;

    bus.m_axi_awaddr  = BASE_ADDR + {28'd0, k_q, 2'b00};
    bus.m_axi_awprot  = '0;
    bus.m_axi_awvalid = (state_q == S_WR) && aw_pend_q;
    bus.m_axi_wdata   = wdata_sel;
    bus.m_axi_wstrb   = '1;
    bus.m_axi_wvalid  = (state_q == S_WR) && w_pend_q;
    bus.m_axi_bready  = (state_q == S_WB);
    bus.m_axi_araddr  = BASE_ADDR + 32'h0000_000C;
    bus.m_axi_arprot  = '0;
    bus.m_axi_arvalid = (state_q == S_RA);
    bus.m_axi_rready  = (state_q == S_RD);
  end

endmodule

// File: tb/tb_mult_add_job_scheduler.sv
// Directed bench for mult_add_job_scheduler with a behavioural MyCpuMult
// AXI4-Lite slave (optional stalls and SLVERR on the B register).
module tb_mult_add_job_scheduler;

  localparam logic [31:0] BASE = 32'h4000_1000;

  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  mult_add_job_scheduler_if bus();

  mult_add_job_scheduler #(.BASE_ADDR(BASE), .DATA_W(32)) dut (
    .ACLK  (ACLK),
    .ARESET(ARESET),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // ---------------- peripheral model ----------------
  logic        bp_en = 1'b0;
  logic        slverr_en = 1'b0;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  int          aw_dly = 0, w_off = 1, ar_dly = 0;
  int          n_aw = 0, n_w = 0, n_ar = 0, n_wr_c = 0;
  logic        aw_got = 1'b0, w_got = 1'b0;
  logic [31:0] aw_addr_q = '0, w_data_q = '0;
  logic [31:0] reg_a = '0, reg_b = '0, reg_c = '0;
  logic        bvalid = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = '0;
  logic [31:0] rdata = '0;
  logic        aw_hs, w_hs, a_now, d_now, wr_now;
  logic [31:0] addr_now, data_now, off_now;

  assign bus.m_axi_awready = !bp_en || (aw_cnt == aw_dly);
  assign bus.m_axi_wready  = !bp_en || (w_cnt == (aw_dly + w_off) % 6);
  assign bus.m_axi_arready = !bp_en || (ar_cnt == ar_dly);
  assign bus.m_axi_bvalid  = bvalid;
  assign bus.m_axi_bresp   = bresp;
  assign bus.m_axi_rvalid  = rvalid;
  assign bus.m_axi_rdata   = rdata;
  assign bus.m_axi_rresp   = 2'b00;

  assign aw_hs    = bus.m_axi_awvalid && bus.m_axi_awready;
  assign w_hs     = bus.m_axi_wvalid && bus.m_axi_wready;
  assign a_now    = aw_got || aw_hs;
  assign d_now    = w_got || w_hs;
  assign wr_now   = a_now && d_now && !bvalid;
  assign addr_now = aw_got ? aw_addr_q : bus.m_axi_awaddr;
  assign data_now = w_got ? w_data_q : bus.m_axi_wdata;
  assign off_now  = addr_now - BASE;

  always @(posedge ACLK) begin
    if (ARESET) begin
      bvalid <= 1'b0; rvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
    end else begin
      if (aw_hs) begin n_aw <= n_aw + 1; aw_cnt <= 0; end
      else if (bus.m_axi_awvalid) aw_cnt <= aw_cnt + 1;
      if (w_hs) begin n_w <= n_w + 1; w_cnt <= 0; end
      else if (bus.m_axi_wvalid) w_cnt <= w_cnt + 1;
      if (wr_now) begin
        bvalid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
        bresp  <= (slverr_en && off_now == 32'h4) ? 2'b10 : 2'b00;
        if (off_now == 32'h0) reg_a <= data_now;
        if (off_now == 32'h4) reg_b <= data_now;
        if (off_now == 32'h8) begin reg_c <= data_now; n_wr_c <= n_wr_c + 1; end
      end else begin
        if (aw_hs) begin aw_got <= 1'b1; aw_addr_q <= bus.m_axi_awaddr; end
        if (w_hs) begin w_got <= 1'b1; w_data_q <= bus.m_axi_wdata; end
      end
      if (bvalid && bus.m_axi_bready) begin
        bvalid <= 1'b0;
        aw_dly <= $urandom_range(0, 5);
        w_off  <= $urandom_range(1, 5);
      end
      if (bus.m_axi_arvalid && bus.m_axi_arready) begin
        rvalid <= 1'b1;
        rdata  <= (bus.m_axi_araddr == BASE + 32'hC) ? reg_a * reg_b + reg_c : 32'hDEAD_BEEF;
        n_ar   <= n_ar + 1;
        ar_cnt <= 0;
        ar_dly <= $urandom_range(0, 5);
      end else if (bus.m_axi_arvalid) ar_cnt <= ar_cnt + 1;
      if (rvalid && bus.m_axi_rready) rvalid <= 1'b0;
    end
  end

  // ---------------- stability monitor ----------------
  int          viol = 0;
  logic        p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0, p_rsp = 1'b0;
  logic [31:0] p_awaddr = '0, p_wdata = '0, p_rdata = '0;
  logic        p_rid = 1'b0, p_rerr = 1'b0;

  always @(posedge ACLK) begin
    if (ARESET) begin
      p_aw <= 1'b0; p_w <= 1'b0; p_ar <= 1'b0; p_rsp <= 1'b0;
    end else begin
      if (p_aw && !(bus.m_axi_awvalid && bus.m_axi_awaddr == p_awaddr)) viol <= viol + 1;
      if (p_w && !(bus.m_axi_wvalid && bus.m_axi_wdata == p_wdata)) viol <= viol + 1;
      if (p_ar && !bus.m_axi_arvalid) viol <= viol + 1;
      if (p_rsp && !(bus.rsp_valid && bus.rsp_data == p_rdata &&
                     bus.rsp_id == p_rid && bus.rsp_err == p_rerr)) viol <= viol + 1;
      p_aw     <= bus.m_axi_awvalid && !bus.m_axi_awready;
      p_w      <= bus.m_axi_wvalid && !bus.m_axi_wready;
      p_ar     <= bus.m_axi_arvalid && !bus.m_axi_arready;
      p_rsp    <= bus.rsp_valid && !bus.rsp_ready;
      p_awaddr <= bus.m_axi_awaddr;
      p_wdata  <= bus.m_axi_wdata;
      p_rdata  <= bus.rsp_data;
      p_rid    <= bus.rsp_id;
      p_rerr   <= bus.rsp_err;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept_rsp();
    bus.rsp_ready = 1'b1;
    @(negedge ACLK);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic wait_rsp();
    int w;
    w = 0;
    while (!bus.rsp_valid && w < 300) begin @(negedge ACLK); w++; end
    chk("rsp_valid_seen", 32'(bus.rsp_valid), 32'd1);
  endtask

  // Presents a job, waits for its grant and returns the accept-to-rsp_valid latency.
  task automatic do_job(input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, output int lat);
    int w;
    logic [1:0] g;
    g = (r == 1) ? 2'b10 : 2'b01;
    bus.req_a[r*32 +: 32] = a;
    bus.req_b[r*32 +: 32] = b;
    bus.req_c[r*32 +: 32] = c;
    bus.req_valid[r] = 1'b1;
    #1;
    w = 0;
    while (bus.req_ready !== g && w < 100) begin @(negedge ACLK); #1; w++; end
    chk("grant", 32'(bus.req_ready), 32'(g));
    lat = 0;
    do begin
      @(negedge ACLK);
      lat++;
      if (lat == 1) bus.req_valid[r] = 1'b0;
    end while (!bus.rsp_valid && lat < 300);
    chk("rsp_valid_seen", 32'(bus.rsp_valid), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  int lat, b_aw, b_w, b_ar, b_c, w;

  initial begin
    ARESET = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_a = {32'd10, 32'd2};
    bus.req_b = {32'd10, 32'd3};
    bus.req_c = {32'd0, 32'd1};
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge ACLK);

    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_axi_valids", 32'({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready,
                               bus.m_axi_arvalid, bus.m_axi_rready}), 32'd0);
    chk("rst_rsp", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_err}), 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("tie_prot_strb", 32'({bus.m_axi_awprot, bus.m_axi_arprot, bus.m_axi_wstrb}), 32'h00F);

    // Both requesters valid at reset release: grants alternate 0,1,0,1.
    ARESET = 1'b0;
    #1;
    chk("tie_first_grant", 32'(bus.req_ready), 32'h1);
    for (int j = 0; j < 4; j++) begin
      wait_rsp();
      chk("rr_id", 32'(bus.rsp_id), (j % 2 == 0) ? 32'd0 : 32'd1);
      chk("rr_data", bus.rsp_data, (j % 2 == 0) ? 32'd7 : 32'd100);
      chk("rr_busy_no_ready", 32'(bus.req_ready), 32'd0);
      if (j == 3) bus.req_valid = 2'b00;
      accept_rsp();
    end

    // Single job with a zero-wait slave.
    b_aw = n_aw; b_w = n_w; b_ar = n_ar; b_c = n_wr_c;
    do_job(0, 32'd3, 32'd4, 32'd5, lat);
    chk("single_latency", 32'(lat), 32'd9);
    chk("single_data", bus.rsp_data, 32'd17);
    chk("single_id_err", 32'({bus.rsp_id, bus.rsp_err}), 32'd0);
    chk("single_aw_w_ar", 32'({8'(n_aw - b_aw), 8'(n_w - b_w), 8'(n_ar - b_ar), 8'(n_wr_c - b_c)}),
        32'h0303_0101);
    accept_rsp();

    // 32-bit wrap-around of A*B+C.
    do_job(1, 32'hFFFF_FFFF, 32'd2, 32'd1, lat);
    chk("wrap_data", bus.rsp_data, 32'hFFFF_FFFF);
    chk("wrap_id_err", 32'({bus.rsp_id, bus.rsp_err}), 32'h2);
    accept_rsp();

    // SLVERR on the B register write aborts the job.
    slverr_en = 1'b1;
    b_aw = n_aw; b_w = n_w; b_ar = n_ar; b_c = n_wr_c;
    do_job(0, 32'd1, 32'd2, 32'd3, lat);
    chk("slverr_err", 32'(bus.rsp_err), 32'd1);
    chk("slverr_data", bus.rsp_data, 32'd0);
    chk("slverr_aw_w_ar", 32'({8'(n_aw - b_aw), 8'(n_w - b_w), 8'(n_ar - b_ar), 8'(n_wr_c - b_c)}),
        32'h0202_0000);
    accept_rsp();
    slverr_en = 1'b0;

    // Stalled AW/W/AR plus a response held off for 10 cycles.
    bp_en = 1'b1;
    b_aw = n_aw; b_w = n_w; b_ar = n_ar;
    do_job(1, 32'd6, 32'd7, 32'd8, lat);
    repeat (10) @(negedge ACLK);
    chk("bp_held_valid", 32'(bus.rsp_valid), 32'd1);
    chk("bp_data", bus.rsp_data, 32'd50);
    chk("bp_id_err", 32'({bus.rsp_id, bus.rsp_err}), 32'h2);
    chk("bp_aw_w_ar", 32'({8'(n_aw - b_aw), 8'(n_w - b_w), 8'(n_ar - b_ar)}), 32'h03_0301);
    chk("bp_stability", 32'(viol), 32'd0);
    accept_rsp();
    bp_en = 1'b0;

    // Reset pulsed once the A write has completed.
    b_aw = n_aw; b_w = n_w;
    bus.req_a[31:0] = 32'd9; bus.req_b[31:0] = 32'd9; bus.req_c[31:0] = 32'd9;
    bus.req_valid[0] = 1'b1;
    @(negedge ACLK);
    bus.req_valid[0] = 1'b0;
    w = 0;
    while (!(n_aw > b_aw && n_w > b_w) && w < 100) begin @(negedge ACLK); w++; end
    chk("midrst_a_written", 32'({8'(n_aw - b_aw), 8'(n_w - b_w)}), 32'h0101);
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("midrst_axi_valids", 32'({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready,
                                  bus.m_axi_arvalid, bus.m_axi_rready, bus.req_ready}), 32'd0);
    chk("midrst_rsp", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_err}), 32'd0);
    chk("midrst_rsp_data", bus.rsp_data, 32'd0);
    ARESET = 1'b0;
    b_aw = n_aw; b_w = n_w; b_ar = n_ar;
    do_job(0, 32'd5, 32'd5, 32'd5, lat);
    chk("post_rst_latency", 32'(lat), 32'd9);
    chk("post_rst_data", bus.rsp_data, 32'd30);
    chk("post_rst_aw_w_ar", 32'({8'(n_aw - b_aw), 8'(n_w - b_w), 8'(n_ar - b_ar)}), 32'h03_0301);
    accept_rsp();
    chk("final_stability", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
